// File: rtl/seqdiv_if.sv
// Start/done handshake, operands and results of the sequential divider.
interface seqdiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     X;
  logic [WIDTH-1:0]     Y;
  logic                 busy;
  logic                 done;
  logic                 div_zero;
  logic [WIDTH-1:0]     Z_Low;
  logic [WIDTH-1:0]     Z_High;
  logic [2*WIDTH-1:0]   Z;

  modport master (
    output start, signed_op, X, Y,
    input  busy, done, div_zero, Z_Low, Z_High, Z
  );

  modport slave (
    input  start, signed_op, X, Y,
    output busy, done, div_zero, Z_Low, Z_High, Z
  );
endinterface

// File: rtl/seqdiv.sv
// Non-restoring sequential divider: one quotient bit per clock, signed or unsigned,
// quotient in Z_Low and remainder in Z_High.
module seqdiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seqdiv_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RW    = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] x_q,    x_d;
  logic [WIDTH-1:0] y_q,    y_d;
  logic             sop_q,  sop_d;
  logic [RW-1:0]    r_q,    r_d;
  logic [WIDTH-1:0] q_q,    q_d;
  logic [WIDTH-1:0] dv_q,   dv_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q,   dz_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] zlo_q,  zlo_d;
  logic [WIDTH-1:0] zhi_q,  zhi_d;
  logic             dzo_q,  dzo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             x_neg, y_neg;
  logic [RW-1:0]    r_sh, r_step, r_fix;
  logic [WIDTH-1:0] q_fin, r_fin;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_PREP;
      S_PREP: state_d = S_ITER;
      S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    sop_d  = sop_q;
    r_d    = r_q;
    q_d    = q_q;
    dv_d   = dv_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    cnt_d  = cnt_q;
    zlo_d  = zlo_q;
    zhi_d  = zhi_q;
    dzo_d  = dzo_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    x_neg  = 1'b0;
    y_neg  = 1'b0;
    r_sh   = '0;
    r_step = '0;
    r_fix  = '0;
    q_fin  = '0;
    r_fin  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d   = bus.X;
          y_d   = bus.Y;
          sop_d = bus.signed_op;
          dzo_d = 1'b0;
        end
      end
      S_PREP: begin
        x_neg  = sop_q & x_q[WIDTH-1];
        y_neg  = sop_q & y_q[WIDTH-1];
        q_d    = x_neg ? WIDTH'(-x_q) : x_q;
        dv_d   = y_neg ? WIDTH'(-y_q) : y_q;
        qneg_d = x_neg ^ y_neg;
        rneg_d = x_neg;
        dz_d   = (y_q == '0);
        r_d    = '0;
        cnt_d  = CNT_W'(WIDTH);
      end
      S_ITER: begin
        // Decision uses the pre-shift sign: the shifted value may wrap, the step result cannot.
        r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_step = r_q[WIDTH] ? (r_sh + {1'b0, dv_q}) : (r_sh - {1'b0, dv_q});
        r_d    = r_step;
        q_d    = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
        cnt_d  = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        r_fix  = r_q[WIDTH] ? (r_q + {1'b0, dv_q}) : r_q;
        q_fin  = qneg_q ? WIDTH'(-q_q) : q_q;
        r_fin  = rneg_q ? WIDTH'(-r_fix[WIDTH-1:0]) : r_fix[WIDTH-1:0];
        if (dz_q) begin
          zlo_d = '1;
          zhi_d = x_q;
        end else begin
          zlo_d = q_fin;
          zhi_d = r_fin;
        end
        dzo_d  = dz_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      sop_q  <= 1'b0;
      r_q    <= '0;
      q_q    <= '0;
      dv_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      cnt_q  <= '0;
      zlo_q  <= '0;
      zhi_q  <= '0;
      dzo_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sop_q  <= sop_d;
      r_q    <= r_d;
      q_q    <= q_d;
      dv_q   <= dv_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      cnt_q  <= cnt_d;
      zlo_q  <= zlo_d;
      zhi_q  <= zhi_d;
      dzo_q  <= dzo_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dzo_q;
  assign bus.Z_Low    = zlo_q;
  assign bus.Z_High   = zhi_q;
  assign bus.Z        = {zhi_q, zlo_q};

endmodule

// File: tb/tb_seqdiv.sv
// Directed bench for seqdiv: arithmetic, boundaries, handshake and async reset.
module tb_seqdiv;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  seqdiv_if #(.WIDTH(32)) bus ();

  seqdiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request, let one edge accept it, then scramble the operand inputs.
  task automatic do_start(input logic s, input logic [31:0] x, input logic [31:0] y);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.X         = x;
    bus.Y         = y;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.X         = $urandom;
    bus.Y         = $urandom;
  endtask

  // Edges counted from the accept edge until done is seen (bounded).
  task automatic wait_done(input int start_cnt, output int cyc);
    cyc = start_cnt;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.X = '0; bus.Y = '0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_chk++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dz: got %b want 0", bus.div_zero); end
    n_chk++; if (bus.Z !== 64'd0) begin n_fail++; $display("FAIL rst_z: got %h want 0", bus.Z); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_signed;
    int cyc;
    do_start(1'b1, 32'd100, 32'd7);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL s1_busy: got %b want 1", bus.busy); end
    wait_done(0, cyc);
    n_chk++; if (cyc !== 34) begin n_fail++; $display("FAIL s1_lat: got %0d want 34", cyc); end
    n_chk++; if (bus.Z_Low !== 32'd14) begin n_fail++; $display("FAIL s1_q: got %h want %h", bus.Z_Low, 32'd14); end
    n_chk++; if (bus.Z_High !== 32'd2) begin n_fail++; $display("FAIL s1_r: got %h want %h", bus.Z_High, 32'd2); end
    n_chk++; if (bus.Z !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL s1_z: got %h want 000000020000000e", bus.Z); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL s1_busy_done: got %b want 0", bus.busy); end
    n_chk++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL s1_dz: got %b want 0", bus.div_zero); end
    @(posedge clk); #1;
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL s1_pulse: got %b want 0", bus.done); end
    n_chk++; if (bus.Z_Low !== 32'd14) begin n_fail++; $display("FAIL s1_hold: got %h want %h", bus.Z_Low, 32'd14); end

    do_start(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL s2_q: got %h want fffffff2", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL s2_r: got %h want fffffffe", bus.Z_High); end

    do_start(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL s3_q: got %h want fffffff2", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd2) begin n_fail++; $display("FAIL s3_r: got %h want 2", bus.Z_High); end

    do_start(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'd14) begin n_fail++; $display("FAIL s4_q: got %h want e", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL s4_r: got %h want fffffffe", bus.Z_High); end
  endtask

  task automatic test_unsigned;
    int cyc;
    do_start(1'b0, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL u1_q: got %h want 7fffffff", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd1) begin n_fail++; $display("FAIL u1_r: got %h want 1", bus.Z_High); end

    do_start(1'b1, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'd0) begin n_fail++; $display("FAIL u2_q: got %h want 0", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL u2_r: got %h want ffffffff", bus.Z_High); end

    do_start(1'b0, 32'hF000_0000, 32'h8000_0001);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'd1) begin n_fail++; $display("FAIL u3_q: got %h want 1", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'h6FFF_FFFF) begin n_fail++; $display("FAIL u3_r: got %h want 6fffffff", bus.Z_High); end
  endtask

  task automatic test_boundary;
    int cyc;
    do_start(1'b0, 32'd1234, 32'd0);
    wait_done(0, cyc);
    n_chk++; if (cyc !== 34) begin n_fail++; $display("FAIL dz_lat: got %0d want 34", cyc); end
    n_chk++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", bus.div_zero); end
    n_chk++; if (bus.Z_Low !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_q: got %h want ffffffff", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd1234) begin n_fail++; $display("FAIL dz_r: got %h want 4d2", bus.Z_High); end
    repeat (3) @(posedge clk); #1;
    n_chk++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b want 1", bus.div_zero); end

    do_start(1'b1, 32'hFFFF_FFFB, 32'd0);
    n_chk++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear: got %b want 0", bus.div_zero); end
    wait_done(0, cyc);
    n_chk++; if (bus.Z_High !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL dzs_r: got %h want fffffffb", bus.Z_High); end
    n_chk++; if (bus.Z_Low !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dzs_q: got %h want ffffffff", bus.Z_Low); end

    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, cyc);
    n_chk++; if (bus.Z_Low !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_q: got %h want 80000000", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd0) begin n_fail++; $display("FAIL ovf_r: got %h want 0", bus.Z_High); end
    n_chk++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_dz: got %b want 0", bus.div_zero); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    do_start(1'b1, 32'd100, 32'd7);
    cyc = 0;
    repeat (9) begin @(posedge clk); #1; cyc++; end
    bus.start = 1'b1; bus.signed_op = 1'b1; bus.X = 32'd9; bus.Y = 32'd3;
    @(posedge clk); #1; cyc++;
    bus.start = 1'b0;
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
    wait_done(cyc, cyc);
    n_chk++; if (cyc !== 34) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 34", cyc); end
    n_chk++; if (bus.Z_Low !== 32'd14) begin n_fail++; $display("FAIL b2b_q1: got %h want e", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd2) begin n_fail++; $display("FAIL b2b_r1: got %h want 2", bus.Z_High); end
    do_start(1'b1, 32'd9, 32'd3);
    wait_done(0, cyc);
    n_chk++; if (cyc !== 34) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 34", cyc); end
    n_chk++; if (bus.Z_Low !== 32'd3) begin n_fail++; $display("FAIL b2b_q2: got %h want 3", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd0) begin n_fail++; $display("FAIL b2b_r2: got %h want 0", bus.Z_High); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int n_done;
    do_start(1'b0, 32'd100, 32'd7);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rm_done: got %b want 0", bus.done); end
    n_chk++; if (bus.Z !== 64'd0) begin n_fail++; $display("FAIL rm_z: got %h want 0", bus.Z); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) n_done++; end
    n_chk++; if (n_done !== 0) begin n_fail++; $display("FAIL rm_nodone: got %0d pulses want 0", n_done); end
    do_start(1'b0, 32'd50, 32'd5);
    wait_done(0, cyc);
    n_chk++; if (cyc !== 34) begin n_fail++; $display("FAIL rm_lat: got %0d want 34", cyc); end
    n_chk++; if (bus.Z_Low !== 32'd10) begin n_fail++; $display("FAIL rm_q: got %h want a", bus.Z_Low); end
    n_chk++; if (bus.Z_High !== 32'd0) begin n_fail++; $display("FAIL rm_r: got %h want 0", bus.Z_High); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_signed();
    test_unsigned();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
